// File: rtl/multi_one_shot_pkg.sv
// Shared types and constants for the multi-channel one-shot pulse generator.
// States, edge-mode encodings and counter sizing helper.
package multi_one_shot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } t_1shot_state;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  // Down-counter must hold the larger of the pulse and holdoff reloads.
  function automatic int cnt_width(input int p, input int h);
    int m;
    m = (p > h) ? p : h;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/one_shot_channel.sv
// One channel: optional synchronizer (MULTI_ONE_SHOT_SYNC_EN), input sample,
// edge detect, pulse/holdoff FSM with down-counter and registered outputs.
module one_shot_channel
  import multi_one_shot_pkg::*;
#(
  parameter int PULSE_LEN = 1,
  parameter int HOLDOFF   = 0,
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic en,
  output logic y,
  output logic busy
);

  localparam int CW = cnt_width(PULSE_LEN, HOLDOFF);
  localparam logic [CW-1:0] PL_LD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] HO_LD =
    CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  logic         x_in;
  logic         x_r;
  logic         x_q;
  logic         rise;
  logic         fall;
  logic         trig;
  logic         pulse;
  t_1shot_state state;
  logic [CW-1:0] cnt;

`ifdef MULTI_ONE_SHOT_SYNC_EN
  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= x;
      s2 <= s1;
    end
  end

  assign x_in = s2;
`else
  assign x_in = x;
`endif

  // x_r is the sampled level; x_q its previous value for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r <= 1'b0;
      x_q <= 1'b0;
    end else begin
      x_r <= x_in;
      x_q <= x_r;
    end
  end

  assign rise = x_r & ~x_q;
  assign fall = ~x_r & x_q;

  assign trig = (EDGE_MODE == EDGE_FALL) ? fall :
                (EDGE_MODE == EDGE_BOTH) ? (rise | fall) :
                rise;

  assign pulse = (state == ST_PULSE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      y     <= 1'b0;
      busy  <= 1'b0;
    end else begin
      y    <= pulse;
      busy <= (state != ST_IDLE);
      unique case (state)
        ST_IDLE: begin
          if (en && trig) begin
            state <= ST_PULSE;
            cnt   <= PL_LD;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            if (HOLDOFF > 0) begin
              state <= ST_HOLD;
              cnt   <= HO_LD;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_one_shot_fsm.sv
// Multi-channel edge-triggered one-shot; channels are independent instances.
// Optional input synchronizer selected by MULTI_ONE_SHOT_SYNC_EN.
module multi_one_shot_fsm
  import multi_one_shot_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int PULSE_LEN = 1,
  parameter int HOLDOFF   = 0,
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] x,
  input  logic [N_CH-1:0] en,
  output logic [N_CH-1:0] y,
  output logic [N_CH-1:0] busy
);

  if (N_CH < 1) begin : g_bad_nch
    $error("multi_one_shot_fsm: N_CH must be >= 1");
  end
  if (PULSE_LEN < 1) begin : g_bad_len
    $error("multi_one_shot_fsm: PULSE_LEN must be >= 1");
  end
  if (HOLDOFF < 0) begin : g_bad_hold
    $error("multi_one_shot_fsm: HOLDOFF must be >= 0");
  end
  if (EDGE_MODE != EDGE_RISE && EDGE_MODE != EDGE_FALL &&
      EDGE_MODE != EDGE_BOTH) begin : g_bad_mode
    $error("multi_one_shot_fsm: EDGE_MODE must be 0, 1 or 2");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    one_shot_channel #(
      .PULSE_LEN (PULSE_LEN),
      .HOLDOFF   (HOLDOFF),
      .EDGE_MODE (EDGE_MODE)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .x    (x[i]),
      .en   (en[i]),
      .y    (y[i]),
      .busy (busy[i])
    );
  end

endmodule
